prio_scan_encoder: RTL and testbench
====================================

PRIO_SCAN_ENCODER -- requirements
Module: prio_scan_encoder

Interface
REQ-001 Parameter WIDTH, default 16, SHALL set the request vector width; legal values are powers of two from 2 to 256.
REQ-002 Localparam IDX_W, equal to $clog2(WIDTH), SHALL set the index width.
REQ-003 clk  in  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 in_valid  in  1  in_data and mode are valid this cycle.
REQ-006 in_ready  out  1  block accepts a vector this cycle.
REQ-007 in_data  in  WIDTH  request vector to encode.
REQ-008 mode  in  1  scan order: 0 = LSB-first, 1 = MSB-first.
REQ-009 out_valid  out  1  out_idx, out_last, out_zero and out_seq are valid.
REQ-010 out_ready  in  1  consumer accepts the current beat.
REQ-011 out_idx  out  IDX_W  bit position of the current set bit.
REQ-012 out_seq  out  IDX_W+1  beat number within the current vector, starting at 0.
REQ-013 out_last  out  1  current beat is the final beat of the vector.
REQ-014 out_zero  out  1  accepted vector was all-zero.
REQ-015 status  out  1  busy: high while a vector is held (FSM state SCAN).

Function
REQ-016 The FSM SHALL have exactly two states, IDLE and SCAN.
REQ-017 in_ready SHALL equal (state == IDLE); there is no overlap between vectors.
REQ-018 Acceptance occurs on a cycle where in_valid and in_ready are both high. On acceptance: pending <= in_data, mode_q <= mode, seq <= 0, zero_q <= (in_data == 0), state <= SCAN.
REQ-019 out_valid SHALL equal (state == SCAN), so the first beat appears 1 cycle after acceptance.
REQ-020 out_idx SHALL be the index of the lowest set bit of pending when mode_q = 0, or the highest set bit when mode_q = 1.
REQ-021 out_idx SHALL be 0 when pending is zero.
REQ-022 out_last SHALL be high when pending has at most one bit set.
REQ-023 out_zero SHALL equal zero_q, and out_seq SHALL equal seq.
REQ-024 On an output handshake (out_valid and out_ready): clear bit out_idx of pending and increment seq; if out_last is high, state <= IDLE.
REQ-025 While out_valid is high and out_ready is low, all out_* signals SHALL hold stable; no beat is skipped or repeated.
REQ-026 A vector with k set bits (k ≥ 1) SHALL produce exactly k beats; an all-zero vector SHALL produce exactly one beat with out_zero=1, out_idx=0, out_last=1.
REQ-027 Changes on mode or in_data during SCAN SHALL have no effect.
REQ-028 With out_ready held high, throughput SHALL be one beat per cycle, plus 1 idle cycle between vectors.
REQ-029 An all-ones vector SHALL yield WIDTH beats, with out_seq reaching WIDTH-1 without wrap-around.

Reset
REQ-030 When rst_n is low, the block SHALL immediately enter IDLE and clear pending, seq, zero_q and mode_q to 0.
REQ-031 During reset, out_valid, out_idx, out_seq, out_last, out_zero and status SHALL be 0, and in_ready SHALL be 1.
REQ-032 Reset asserted mid-scan SHALL discard the remaining beats; no beat is emitted after release until a new acceptance.

Structure
REQ-033 Package prio_scan_pkg SHALL hold the state_e enum (IDLE, SCAN) and constants MODE_LSB=1'b0 and MODE_MSB=1'b1.
REQ-034 Combinational sub-module find_first_set (parameters WIDTH and MSB_FIRST) SHALL compute the index and one-hot flag; two instances, or one with a bit-reversed input, select by mode_q.
REQ-035 The top level SHALL contain only the FSM, the pending/seq registers and the handshake logic.

Verification (WIDTH=16, out_ready=1 unless stated)
REQ-036 in_data=0x0001, mode=0 -> one beat: idx=0, seq=0, last=1, zero=0; in_ready returns to 1 the next cycle.
REQ-037 in_data=0x8421, mode=0 -> idx sequence 0, 5, 10, 15 on consecutive cycles; seq 0..3; last only on idx 15.
REQ-038 in_data=0x8421, mode=1 -> idx sequence 15, 10, 5, 0; last only on idx 0; toggling mode mid-scan changes nothing.
REQ-039 in_data=0x0000 -> single beat: zero=1, idx=0, last=1; status high for exactly 1 cycle when out_ready=1.
REQ-040 in_data=0x0120, out_ready low for 3 cycles on beat 0 -> idx=5 held for 4 cycles, then idx=8 with last=1; in_valid=1 during SCAN is not accepted (in_ready=0).
REQ-041 in_data=0xFFFF, reset asserted after beat 3 -> out_valid and status drop to 0 immediately, in_ready=1; after release, no stray beats until the next accept.

Source files
------------

// File: rtl/prio_scan_encoder_pkg.sv
// Shared types and constants for the priority scan encoder.
package prio_scan_pkg;

  // Two-state controller: IDLE accepts a vector, SCAN emits its beats.
  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_e;

  // Scan order encoding carried on the mode input.
  localparam logic MODE_LSB = 1'b0;
  localparam logic MODE_MSB = 1'b1;

endpackage

// File: rtl/prio_scan_encoder_find_first_set.sv
// Combinational first-set-bit finder. MSB_FIRST selects which end of the
// vector wins. at_most_one flags a vector with zero or one bit set, which
// the controller uses to recognise the final beat.
module find_first_set #(
  parameter  int WIDTH     = 16,
  parameter  bit MSB_FIRST = 1'b0,
  localparam int IDX_W     = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] vec,
  output logic [IDX_W-1:0] idx,
  output logic             at_most_one
);

  // Priority search: the last matching iteration wins, so the loop runs
  // from the low-priority end toward the high-priority end.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so
    // no path leaves it unassigned, which would infer a latch.
    idx = '0;
    if (MSB_FIRST) begin
      for (int i = 0; i < WIDTH; i++) begin
        if (vec[i]) idx = IDX_W'(i);
      end
    end else begin
      for (int i = WIDTH - 1; i >= 0; i--) begin
        if (vec[i]) idx = IDX_W'(i);
      end
    end
  end

  // Clearing the lowest set bit leaves zero only when at most one was set.
  assign at_most_one = ((vec & (vec - 1'b1)) == '0);

endmodule

// File: rtl/prio_scan_encoder.sv
// Priority scan encoder: accepts a request vector, then emits one beat per
// set bit (LSB-first or MSB-first) over a valid/ready output stream. An
// all-zero vector produces a single beat flagged with out_zero.
module prio_scan_encoder
  import prio_scan_pkg::*;
#(
  parameter  int WIDTH = 16,
  localparam int IDX_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] out_idx,
  output logic [IDX_W:0]   out_seq,
  output logic             out_last,
  output logic             out_zero,
  output logic             status
);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   pending;
  logic [WIDTH-1:0]   pending_clr;
  logic [IDX_W:0]     seq;
  logic               zero_q;
  logic               mode_q;

  logic [IDX_W-1:0]   lsb_idx, msb_idx, sel_idx;
  logic               lsb_single, msb_single;
  logic               sel_last;
  logic               accept, out_fire;

  find_first_set #(.WIDTH(WIDTH), .MSB_FIRST(1'b0)) u_ffs_lsb (
    .vec         (pending),
    .idx         (lsb_idx),
    .at_most_one (lsb_single)
  );

  find_first_set #(.WIDTH(WIDTH), .MSB_FIRST(1'b1)) u_ffs_msb (
    .vec         (pending),
    .idx         (msb_idx),
    .at_most_one (msb_single)
  );

  // Both finders see the same vector, so the single-bit flags always agree;
  // the captured mode only picks which index is reported.
  assign sel_idx  = (mode_q == MODE_MSB) ? msb_idx : lsb_idx;
  assign sel_last = (mode_q == MODE_MSB) ? msb_single : lsb_single;

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == SCAN);
  assign status    = out_valid;
  assign accept    = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;

  // pending is zero whenever nothing is held, so the index needs no gating;
  // last is gated so it reads low while idle and during reset.
  assign out_idx  = sel_idx;
  assign out_last = out_valid && sel_last;
  assign out_zero = zero_q;
  assign out_seq  = seq;

  // Retire the bit just emitted.
  always_comb begin
    pending_clr          = pending;
    pending_clr[sel_idx] = 1'b0;
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every
    // register samples pre-edge values regardless of statement order.
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic: one vector at a time, leave SCAN on the last beat.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (in_valid)              state_d = SCAN;
      SCAN: if (out_ready && sel_last) state_d = IDLE;
      default:                         state_d = IDLE;
    endcase
  end

  // Vector capture on acceptance, bit retirement and beat counting on each
  // output handshake. Inputs are ignored entirely while scanning.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending <= '0;
      seq     <= '0;
      zero_q  <= 1'b0;
      mode_q  <= MODE_LSB;
    end else if (accept) begin
      pending <= in_data;
      seq     <= '0;
      zero_q  <= (in_data == '0);
      mode_q  <= mode;
    end else if (out_fire) begin
      pending <= pending_clr;
      seq     <= seq + 1'b1;
    end
  end

endmodule

// File: tb/tb_prio_scan_encoder.sv
// Directed bench for prio_scan_encoder at WIDTH=16. Inputs change 1 time
// unit after each rising edge and outputs are checked right after.
module tb_prio_scan_encoder;

  localparam int WIDTH = 16;
  localparam int IDX_W = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] in_data = '0;
  logic             mode = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [IDX_W-1:0] out_idx;
  logic [IDX_W:0]   out_seq;
  logic             out_last;
  logic             out_zero;
  logic             status;

  int n_assert = 0;
  int n_fail   = 0;

  prio_scan_encoder #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .mode      (mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_idx   (out_idx),
    .out_seq   (out_seq),
    .out_last  (out_last),
    .out_zero  (out_zero),
    .status    (status)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Full beat check: valid, index, sequence number, last and zero flags.
  task automatic beat(input string tag, input int idx, input int seq, input bit last, input bit zero);
    check({tag, " valid"}, 32'(out_valid), 32'd1);
    check({tag, " idx"},   32'(out_idx),   32'(idx));
    check({tag, " seq"},   32'(out_seq),   32'(seq));
    check({tag, " last"},  32'(out_last),  32'(last));
    check({tag, " zero"},  32'(out_zero),  32'(zero));
    check({tag, " ready"}, 32'(in_ready),  32'd0);
  endtask

  // Present a vector in an IDLE cycle; returns with the first beat visible.
  task automatic send(input logic [WIDTH-1:0] data, input logic m);
    check("accept in_ready", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    in_data  = data;
    mode     = m;
    step();
    in_valid = 1'b0;
  endtask

  task automatic expect_idle(input string tag);
    check({tag, " out_valid"}, 32'(out_valid), 32'd0);
    check({tag, " status"},    32'(status),    32'd0);
    check({tag, " in_ready"},  32'(in_ready),  32'd1);
  endtask

  initial begin
    // Reset state.
    #2;
    check("rst out_valid", 32'(out_valid), 32'd0);
    check("rst in_ready",  32'(in_ready),  32'd1);
    check("rst idx",       32'(out_idx),   32'd0);
    check("rst seq",       32'(out_seq),   32'd0);
    check("rst last",      32'(out_last),  32'd0);
    check("rst zero",      32'(out_zero),  32'd0);
    check("rst status",    32'(status),    32'd0);
    step();
    rst_n = 1'b1;
    step();
    expect_idle("post-rst");

    // Single bit, LSB-first.
    send(16'h0001, 1'b0);
    beat("one b0", 0, 0, 1'b1, 1'b0);
    check("one status", 32'(status), 32'd1);
    step();
    expect_idle("one done");

    // 0x8421 LSB-first: 0, 5, 10, 15.
    send(16'h8421, 1'b0);
    beat("lsb b0", 0, 0, 1'b0, 1'b0);  step();
    beat("lsb b1", 5, 1, 1'b0, 1'b0);  step();
    beat("lsb b2", 10, 2, 1'b0, 1'b0); step();
    beat("lsb b3", 15, 3, 1'b1, 1'b0); step();
    expect_idle("lsb done");

    // 0x8421 MSB-first: 15, 10, 5, 0, with mode and data churning mid-scan.
    send(16'h8421, 1'b1);
    beat("msb b0", 15, 0, 1'b0, 1'b0);
    mode = 1'b0; in_data = 16'h00FF; step();
    beat("msb b1", 10, 1, 1'b0, 1'b0);
    mode = 1'b1; in_data = 16'h1234; step();
    beat("msb b2", 5, 2, 1'b0, 1'b0);
    mode = 1'b0; step();
    beat("msb b3", 0, 3, 1'b1, 1'b0); step();
    expect_idle("msb done");

    // All-zero vector: one beat, status for exactly one cycle.
    send(16'h0000, 1'b0);
    beat("zero b0", 0, 0, 1'b1, 1'b1);
    check("zero status", 32'(status), 32'd1);
    step();
    expect_idle("zero done");

    // Back-pressure on beat 0 of 0x0120; in_valid held high during SCAN.
    send(16'h0120, 1'b0);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 16'hFFFF;
    beat("stall c0", 5, 0, 1'b0, 1'b0); step();
    beat("stall c1", 5, 0, 1'b0, 1'b0); step();
    beat("stall c2", 5, 0, 1'b0, 1'b0); step();
    out_ready = 1'b1;
    beat("stall c3", 5, 0, 1'b0, 1'b0); step();
    in_valid = 1'b0;
    beat("stall b1", 8, 1, 1'b1, 1'b0); step();
    expect_idle("stall done");

    // All-ones, LSB-first: 16 beats, seq reaches 15 with no wrap.
    send(16'hFFFF, 1'b0);
    for (int i = 0; i < WIDTH; i++) begin
      check("ones idx",  32'(out_idx),  32'(i));
      check("ones seq",  32'(out_seq),  32'(i));
      check("ones last", 32'(out_last), 32'(i == WIDTH - 1));
      step();
    end
    expect_idle("ones done");

    // All-ones, reset after beat 3 retires.
    send(16'hFFFF, 1'b0);
    beat("rstm b0", 0, 0, 1'b0, 1'b0); step();
    beat("rstm b1", 1, 1, 1'b0, 1'b0); step();
    beat("rstm b2", 2, 2, 1'b0, 1'b0); step();
    beat("rstm b3", 3, 3, 1'b0, 1'b0); step();
    beat("rstm b4", 4, 4, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    expect_idle("rstm async");
    check("rstm idx",  32'(out_idx),  32'd0);
    check("rstm seq",  32'(out_seq),  32'd0);
    check("rstm last", 32'(out_last), 32'd0);
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      expect_idle("rstm quiet");
    end

    // A fresh vector after the aborted scan starts cleanly.
    send(16'h4000, 1'b1);
    beat("after b0", 14, 0, 1'b1, 1'b0); step();
    expect_idle("after done");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
